// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm, wait for a trigger edge, optional delay, then
// capture a bounded (or unbounded) run of trace words into the capture FIFO.
module trace_capture_ctrl #(
  parameter int pCNT_WIDTH   = 32,
  parameter int pTRIGW_WIDTH = 8
) (
  input  logic                    trace_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_abort,
  input  logic                    I_trig,
  input  logic [pCNT_WIDTH-1:0]   I_trig_delay,
  input  logic [pCNT_WIDTH-1:0]   I_capture_len,
  input  logic [pTRIGW_WIDTH-1:0] I_trig_width,
  input  logic                    I_data_valid,
  input  logic                    I_fifo_full,
  output logic                    O_fifo_wr,
  output logic                    O_arm,
  output logic                    O_capturing,
  output logic                    O_trig_out,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic [pCNT_WIDTH-1:0]   O_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_trig_q;
  logic [pCNT_WIDTH-1:0]   r_dly_cnt;
  logic [pCNT_WIDTH-1:0]   r_count;
  logic [pTRIGW_WIDTH-1:0] r_pulse_rem;
  logic                    r_trig_out;
  logic                    r_done;
  logic                    r_overflow;

  logic                    w_trig_rise;
  logic                    w_fire;
  logic                    w_clear;
  logic                    w_wr;
  logic                    w_drop;
  logic                    w_len_hit;
  logic [pCNT_WIDTH-1:0]   w_count_inc;

  assign w_trig_rise = I_trig & ~r_trig_q;
  assign w_wr        = (r_state == S_CAPTURE) & I_data_valid & ~I_fifo_full;
  assign w_drop      = (r_state == S_CAPTURE) & I_data_valid & I_fifo_full;
  assign w_count_inc = (&r_count) ? r_count : r_count + pCNT_WIDTH'(1);
  assign w_len_hit   = w_wr && (I_capture_len != '0) && (w_count_inc == I_capture_len);

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (I_arm && !I_abort) begin
          w_state_next = S_ARMED;
          w_clear      = 1'b1;
        end
      end
      S_ARMED: begin
        if (I_abort) begin
          w_state_next = S_IDLE;
        end else if (w_trig_rise) begin
          w_fire = 1'b1;
          // A delay of 1 lands on the same cycle as no delay: capture starts the cycle after the edge.
          w_state_next = (I_trig_delay > pCNT_WIDTH'(1)) ? S_DELAY : S_CAPTURE;
        end
      end
      S_DELAY: begin
        if (I_abort) begin
          w_state_next = S_IDLE;
        end else if (r_dly_cnt <= pCNT_WIDTH'(1)) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (I_abort || w_len_hit) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_q    <= 1'b0;
      r_dly_cnt   <= '0;
      r_count     <= '0;
      r_pulse_rem <= '0;
      r_trig_out  <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_trig_q <= I_trig;

      if (w_fire) begin
        r_dly_cnt <= I_trig_delay - pCNT_WIDTH'(1);
      end else if (r_state == S_DELAY) begin
        r_dly_cnt <= r_dly_cnt - pCNT_WIDTH'(1);
      end

      if (w_clear) begin
        r_count    <= '0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr) begin
          r_count <= w_count_inc;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if ((r_state == S_CAPTURE) && (w_state_next == S_DONE)) begin
          r_done <= 1'b1;
        end
      end

      // Pulse runs to completion regardless of state; new edges are ignored meanwhile.
      if (r_trig_out) begin
        if (r_pulse_rem == '0) begin
          r_trig_out <= 1'b0;
        end else begin
          r_pulse_rem <= r_pulse_rem - pTRIGW_WIDTH'(1);
        end
      end else if (w_fire) begin
        r_trig_out  <= 1'b1;
        r_pulse_rem <= (I_trig_width == '0) ? '0 : I_trig_width - pTRIGW_WIDTH'(1);
      end
    end
  end

  assign O_fifo_wr   = w_wr;
  assign O_arm       = (r_state == S_ARMED) || (r_state == S_DELAY);
  assign O_capturing = (r_state == S_CAPTURE);
  assign O_trig_out  = r_trig_out;
  assign O_done      = r_done;
  assign O_overflow  = r_overflow;
  assign O_count     = r_count;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: directed and random capture scenarios
// compared cycle by cycle against a scenario-level reference model.
module tb_trace_capture_ctrl;

  localparam int CW = 32;
  localparam int TW = 8;
  localparam int N  = 64;

  logic          trace_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          I_arm = 1'b0;
  logic          I_abort = 1'b0;
  logic          I_trig = 1'b0;
  logic [CW-1:0] I_trig_delay = '0;
  logic [CW-1:0] I_capture_len = '0;
  logic [TW-1:0] I_trig_width = '0;
  logic          I_data_valid = 1'b0;
  logic          I_fifo_full = 1'b0;
  logic          O_fifo_wr;
  logic          O_arm;
  logic          O_capturing;
  logic          O_trig_out;
  logic          O_done;
  logic          O_overflow;
  logic [CW-1:0] O_count;

  trace_capture_ctrl #(.pCNT_WIDTH(CW), .pTRIGW_WIDTH(TW)) dut (
    .trace_clk    (trace_clk),
    .reset_n      (reset_n),
    .I_arm        (I_arm),
    .I_abort      (I_abort),
    .I_trig       (I_trig),
    .I_trig_delay (I_trig_delay),
    .I_capture_len(I_capture_len),
    .I_trig_width (I_trig_width),
    .I_data_valid (I_data_valid),
    .I_fifo_full  (I_fifo_full),
    .O_fifo_wr    (O_fifo_wr),
    .O_arm        (O_arm),
    .O_capturing  (O_capturing),
    .O_trig_out   (O_trig_out),
    .O_done       (O_done),
    .O_overflow   (O_overflow),
    .O_count      (O_count)
  );

  always #5 trace_clk = ~trace_clk;

  int checks = 0;
  int errors = 0;

  bit t_a[N];
  bit v_a[N];
  bit f_a[N];
  bit ab_a[N];
  int cfg_d, cfg_l, cfg_w;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_scn(input int d, input int l, input int w);
    cfg_d = d;
    cfg_l = l;
    cfg_w = w;
    for (int k = 0; k < N; k++) begin
      t_a[k] = 1'b0; v_a[k] = 1'b0; f_a[k] = 1'b0; ab_a[k] = 1'b0;
    end
    ab_a[N-1] = 1'b1;
  endtask

  task automatic set_trig_from(input int e);
    for (int k = e; k < N; k++) t_a[k] = 1'b1;
  endtask

  // Reference: abort cycle A, trigger edge E, capture start S, final capture cycle fin.
  task automatic run_scn(input string name, input int stop_at);
    int a_c, e_c, s_c, fin, wd, arm_end, cnt, wr_so_far;
    bit ovf_so_far, exp_cap, exp_wr;
    a_c = -1; e_c = -1; s_c = -1; fin = -1;
    for (int k = 1; k < N; k++) if (ab_a[k] && a_c < 0) a_c = k;
    for (int k = 1; k < a_c; k++) if (t_a[k] && !t_a[k-1] && e_c < 0) e_c = k;
    wd = (cfg_w == 0) ? 1 : cfg_w;
    if (e_c >= 0) begin
      s_c = e_c + ((cfg_d == 0) ? 1 : cfg_d);
      if (s_c > a_c) s_c = -1;
    end
    if (s_c >= 0) begin
      cnt = 0;
      for (int k = s_c; k <= a_c; k++) begin
        if (v_a[k] && !f_a[k]) cnt++;
        if ((cfg_l != 0 && cnt == cfg_l) || k == a_c) begin
          fin = k;
          break;
        end
      end
    end
    arm_end = (s_c >= 0) ? s_c - 1 : a_c;

    I_trig_delay  = CW'(cfg_d);
    I_capture_len = CW'(cfg_l);
    I_trig_width  = TW'(cfg_w);
    wr_so_far  = 0;
    ovf_so_far = 1'b0;
    for (int k = 0; k <= stop_at; k++) begin
      @(negedge trace_clk);
      I_arm        = (k == 0);
      I_trig       = t_a[k];
      I_data_valid = v_a[k];
      I_fifo_full  = f_a[k];
      I_abort      = ab_a[k];
      #1;
      exp_cap = (s_c >= 0) && (k >= s_c) && (k <= fin);
      exp_wr  = exp_cap && v_a[k] && !f_a[k];
      chk($sformatf("%s.wr@%0d", name, k), CW'(O_fifo_wr), CW'(exp_wr));
      chk($sformatf("%s.cap@%0d", name, k), CW'(O_capturing), CW'(exp_cap));
      chk($sformatf("%s.arm@%0d", name, k), CW'(O_arm), CW'((k >= 1) && (k <= arm_end)));
      chk($sformatf("%s.trig@%0d", name, k), CW'(O_trig_out),
          CW'((e_c >= 0) && (k > e_c) && (k <= e_c + wd)));
      if (k >= 1) begin
        chk($sformatf("%s.count@%0d", name, k), O_count, CW'(wr_so_far));
        chk($sformatf("%s.done@%0d", name, k), CW'(O_done), CW'((fin >= 0) && (k > fin)));
        chk($sformatf("%s.ovf@%0d", name, k), CW'(O_overflow), CW'(ovf_so_far));
      end
      if (exp_wr) wr_so_far++;
      if (exp_cap && v_a[k] && f_a[k]) ovf_so_far = 1'b1;
    end
    $display("scenario %s: d=%0d len=%0d w=%0d edge=%0d start=%0d end=%0d writes=%0d",
             name, cfg_d, cfg_l, cfg_w, e_c, s_c, fin, wr_so_far);
  endtask

  initial begin
    int e;
    #12;
    chk("rst.wr", CW'(O_fifo_wr), '0);
    chk("rst.arm", CW'(O_arm), '0);
    chk("rst.cap", CW'(O_capturing), '0);
    chk("rst.trig", CW'(O_trig_out), '0);
    chk("rst.done", CW'(O_done), '0);
    chk("rst.ovf", CW'(O_overflow), '0);
    chk("rst.count", O_count, '0);
    @(negedge trace_clk);
    reset_n = 1'b1;

    new_scn(0, 4, 1); set_trig_from(3);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("len4", N-1);

    new_scn(10, 2, 1); set_trig_from(3);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("delay10", N-1);

    new_scn(0, 3, 5); set_trig_from(2);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("width5", N-1);

    new_scn(0, 3, 0); set_trig_from(2);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("width0", N-1);

    new_scn(0, 8, 1); set_trig_from(2);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    f_a[6] = 1'b1; f_a[7] = 1'b1; f_a[8] = 1'b1;
    run_scn("full3", N-1);

    new_scn(0, 0, 2); set_trig_from(2);
    for (int k = 3; k < 23; k++) v_a[k] = 1'b1;
    ab_a[25] = 1'b1;
    run_scn("unlimited", N-1);

    new_scn(0, 4, 1);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    ab_a[4] = 1'b1;
    run_scn("abort_armed", N-1);

    new_scn(0, 2, 1);
    for (int k = 0; k < 6; k++) t_a[k] = 1'b1;
    set_trig_from(10);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("trig_high_at_arm", N-1);

    for (int r = 0; r < 24; r++) begin
      new_scn(int'($urandom_range(0, 12)), int'($urandom_range(0, 10)), int'($urandom_range(0, 8)));
      e = int'($urandom_range(1, 8));
      t_a[0] = 1'($urandom_range(0, 1));
      set_trig_from(e);
      for (int k = e + 1; k < N; k++) t_a[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        v_a[k] = ($urandom_range(0, 99) < 75);
        f_a[k] = ($urandom_range(0, 99) < 20);
      end
      if ($urandom_range(0, 5) == 0) ab_a[$urandom_range(2, 20)] = 1'b1;
      run_scn($sformatf("rand%0d", r), N-1);
    end

    new_scn(0, 0, 1); set_trig_from(2);
    for (int k = 0; k < N; k++) v_a[k] = 1'b1;
    run_scn("async_rst", 6);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.wr", CW'(O_fifo_wr), '0);
    chk("arst.arm", CW'(O_arm), '0);
    chk("arst.cap", CW'(O_capturing), '0);
    chk("arst.trig", CW'(O_trig_out), '0);
    chk("arst.done", CW'(O_done), '0);
    chk("arst.ovf", CW'(O_overflow), '0);
    chk("arst.count", O_count, '0);
    @(negedge trace_clk);
    I_arm = 1'b0; I_abort = 1'b0; I_trig = 1'b0; I_data_valid = 1'b0; I_fifo_full = 1'b0;
    reset_n = 1'b1;
    @(negedge trace_clk);
    #1;
    chk("arst.idle_cap", CW'(O_capturing), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Sequences one trace capture in the trace clock domain: arm, wait for trigger, optional delay, capture a bounded number of trace words into the capture FIFO, then report done. Sits between the trace matcher/trigger logic and the capture FIFO. Drives the arm/capturing LED status and the external trigger pulse. Register-block inputs arrive already synchronized to trace_clk.

Parameters:
pCNT_WIDTH, 32, width of delay, length and word counters
pTRIGW_WIDTH, 8, width of trigger-out pulse-width setting

Ports:
trace_clk  input  1  sole clock; one clock; reset is asynchronous and active-low
reset_n  input  1  asynchronous active-low reset
I_arm  input  1  single-cycle arm request
I_abort  input  1  single-cycle abort request
I_trig  input  1  trigger-match level; rising edge used
I_trig_delay  input  pCNT_WIDTH  cycles from trigger edge to capture start
I_capture_len  input  pCNT_WIDTH  words to capture; 0 = unlimited
I_trig_width  input  pTRIGW_WIDTH  O_trig_out pulse width in cycles; 0 treated as 1
I_data_valid  input  1  trace word valid this cycle
I_fifo_full  input  1  capture FIFO full
O_fifo_wr  output  1  FIFO write enable (combinational)
O_arm  output  1  high in ARMED and DELAY
O_capturing  output  1  high in CAPTURE
O_trig_out  output  1  trigger pulse to CW
O_done  output  1  sticky; capture finished
O_overflow  output  1  sticky; valid word dropped on full FIFO
O_count  output  pCNT_WIDTH  words written this capture

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters 0; trig edge register 0.
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- IDLE: I_arm -> ARMED next cycle; clears O_done, O_overflow, O_count.
- ARMED: rising edge of I_trig (I_trig=1, previous sample 0) -> DELAY if I_trig_delay!=0, else CAPTURE. I_trig already high on entering ARMED is not an edge.
- DELAY: counts I_trig_delay cycles; CAPTURE entered exactly I_trig_delay cycles after the trigger-edge cycle.
- Trigger-edge cycle: O_trig_out asserted next cycle for max(I_trig_width,1) cycles; pulse completes even if abort/done occurs meanwhile; re-trigger ignored while pulse active.
- CAPTURE: O_fifo_wr = I_data_valid & ~I_fifo_full. Each write increments O_count (registered, visible next cycle). I_data_valid & I_fifo_full -> O_overflow=1, word dropped, capture continues.
- CAPTURE -> DONE when a write makes O_count reach I_capture_len (I_capture_len!=0); no further writes that cycle onward. I_capture_len=0: runs until I_abort.
- DONE: O_done=1 (sticky); O_arm=O_capturing=0; I_arm -> ARMED with O_done/O_overflow/O_count cleared.
- I_abort in ARMED/DELAY -> IDLE (O_done stays 0); in CAPTURE -> DONE; abort wins over simultaneous arm or completion. I_arm outside IDLE/DONE ignored.
- O_count saturates at all-ones; never wraps.
- Config inputs sampled live; held stable by software while armed.

Test Plan:
- Arm, trigger edge with delay=0, len=4, data_valid continuous -> O_capturing next cycle, exactly 4 O_fifo_wr, O_count=4, O_done=1, O_capturing=0.
- delay=10, len=2 -> first O_fifo_wr exactly 10 cycles after trigger-edge cycle; O_arm high through delay.
- I_trig_width=5 -> O_trig_out high exactly 5 cycles starting 1 cycle after edge; width=0 -> 1-cycle pulse.
- I_fifo_full held 3 cycles mid-capture, len=8 -> O_overflow=1, no write those cycles, O_count still reaches 8.
- len=0, 20 valid words then I_abort -> O_count=20, DONE; I_abort in ARMED -> IDLE, O_done=0.
- reset_n low mid-CAPTURE, asynchronously (no clock edge) -> all outputs 0 immediately; I_trig high at arm -> no capture until low-then-high.
